// File: rtl/pll_ctrl_pkg.sv
// ============================================================================
// Module      : pll_ctrl_pkg
// Description : Shared types and constants for the ECP5 PLL phase controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        PULSE  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4,
        RELOCK = 3'd5
    } pll_state_t;

    // EHXPLLL PHASESEL encoding is not in channel order
    localparam logic [1:0] SEL_CLKOP  = 2'b11;
    localparam logic [1:0] SEL_CLKOS  = 2'b00;
    localparam logic [1:0] SEL_CLKOS2 = 2'b01;
    localparam logic [1:0] SEL_CLKOS3 = 2'b10;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_STEP_W    = 8;
    localparam int DEF_SETUP_CYC = 4;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_GAP_CYC   = 8;
    localparam int DEF_LOCK_CYC  = 1024;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_RST_CYC   = 64;

    function automatic logic [1:0] chan_to_sel(input logic [1:0] chan);
        case (chan)
            2'd0:    return SEL_CLKOP;
            2'd1:    return SEL_CLKOS;
            2'd2:    return SEL_CLKOS2;
            default: return SEL_CLKOS3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_filter.sv
// ============================================================================
// Module      : pll_lock_filter
// Description : Synchronises raw PLL LOCK and qualifies it into a ready flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_filter #(
    parameter int LOCK_CYC = 1024,
    parameter int CNT_W    = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pll_lock,
    output logic lock_s,
    output logic pll_ready
);

    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYC);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] lock_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            sync_meta <= pll_lock;
            sync_q    <= sync_meta;
            if (!sync_q)
                lock_cnt <= '0;
            else if (lock_cnt != LOCK_MAX)
                lock_cnt <= lock_cnt + 1'b1;
        end
    end

    // Gating with sync_q drops ready in the same cycle the lock goes away
    assign lock_s    = sync_q;
    assign pll_ready = sync_q && (lock_cnt == LOCK_MAX);

endmodule

`default_nettype wire

// File: rtl/pll_phase_ctrl.sv
// ============================================================================
// Module      : pll_phase_ctrl
// Description : EHXPLLL dynamic phase-shift sequencer and lock supervisor.
//               Optional auto-relock enabled by `define PLL_AUTORELOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int LOCK_CYC  = DEF_LOCK_CYC,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RST_CYC   = DEF_RST_CYC
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pll_lock,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_chan,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              req_err,
    output logic              done,
    output logic              pll_ready,
    output logic              lock_lost,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              phaseloadreg,
    output logic              pll_rst
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);

    pll_state_t        state;
    pll_state_t        next_state;
    logic [CNT_W-1:0]  timer;
    logic [STEP_W-1:0] steps_left;
    logic              lock_s;
    logic              ready_q;
    logic              accept;
    logic              reject;
    logic              chan_ok;
    logic              relock_go;

    pll_lock_filter #(
        .LOCK_CYC (LOCK_CYC),
        .CNT_W    (CNT_W)
    ) u_lock_filter (
        .clock     (clock),
        .reset_n   (reset_n),
        .pll_lock  (pll_lock),
        .lock_s    (lock_s),
        .pll_ready (pll_ready)
    );

    assign chan_ok      = ({1'b0, req_chan} < 3'(NUM_CH));
    assign req_ready    = (state == IDLE) && pll_ready;
    assign phaseloadreg = 1'b1;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (pll_ready && chan_ok) begin
                        accept     = 1'b1;
                        next_state = (req_steps == '0) ? DONE : SETUP;
                    end else begin
                        reject = 1'b1;
                    end
                end
                if (relock_go)
                    next_state = RELOCK;
            end
            SETUP: begin
                if (!pll_ready)
                    next_state = IDLE;
                else if (timer == SETUP_LAST)
                    next_state = PULSE;
            end
            PULSE: begin
                if (!pll_ready)
                    next_state = IDLE;
                else if (timer == PULSE_LAST)
                    next_state = GAP;
            end
            GAP: begin
                if (!pll_ready)
                    next_state = IDLE;
                else if (timer == GAP_LAST)
                    next_state = (steps_left == STEP_W'(1)) ? DONE : PULSE;
            end
            DONE: next_state = IDLE;
            RELOCK: begin
`ifdef PLL_AUTORELOCK_EN
                reject = req_valid;
`endif
                if (timer == RST_LAST)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            steps_left <= '0;
            phasesel   <= 2'b00;
            phasedir   <= 1'b1;
            phasestep  <= 1'b1;
            done       <= 1'b0;
            req_err    <= 1'b0;
            lock_lost  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state <= next_state;
            timer <= (next_state != state || state == IDLE) ? '0 : timer + 1'b1;
            if (accept)
                steps_left <= req_steps;
            else if (state == GAP && timer == GAP_LAST)
                steps_left <= steps_left - 1'b1;
            if (accept && req_steps != '0) begin
                phasesel <= chan_to_sel(req_chan);
                phasedir <= req_dir;
            end
            phasestep <= (next_state != PULSE);
            done      <= (state == DONE);
            req_err   <= reject;
            ready_q   <= pll_ready;
            // Once saturated, ready can only fall through lock_s dropping
            if (ready_q && !lock_s)
                lock_lost <= 1'b1;
            else if (accept)
                lock_lost <= 1'b0;
        end
    end

`ifdef PLL_AUTORELOCK_EN
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYC);

    logic             armed;
    logic [CNT_W-1:0] loss_cnt;
    logic             pll_rst_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed     <= 1'b0;
            loss_cnt  <= '0;
            pll_rst_q <= 1'b0;
        end else begin
            if (state == RELOCK)
                armed <= 1'b0;
            else if (pll_ready)
                armed <= 1'b1;
            if (lock_s || !armed)
                loss_cnt <= '0;
            else if (loss_cnt != LOCK_MAX)
                loss_cnt <= loss_cnt + 1'b1;
            pll_rst_q <= (next_state == RELOCK);
        end
    end

    assign relock_go = armed && (loss_cnt == LOCK_MAX);
    assign pll_rst   = pll_rst_q;
`else
    assign relock_go = 1'b0;
    assign pll_rst   = 1'b0;
`endif

endmodule

`default_nettype wire
